// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy controller.
//   lane_state_e   : per-lane direction FSM state (3-bit, IDLE = 0)
//   DEB_CYCLES_DEF : default debounce length in cycles
//   clamp_occ      : saturate a signed occupancy estimate into [0, cap]
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_A     = 3'd1,
    ST_IN_AB    = 3'd2,
    ST_IN_B     = 3'd3,
    ST_OUT_B    = 3'd4,
    ST_OUT_AB   = 3'd5,
    ST_OUT_A    = 3'd6,
    ST_WAIT_CLR = 3'd7
  } lane_state_e;

  localparam int DEB_CYCLES_DEF = 4;

  function automatic int clamp_occ(input int val, input int cap);
    if (val < 0)   return 0;
    if (val > cap) return cap;
    return val;
  endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// One sensor lane: 2-flop synchronisers, pair debouncer and direction FSM.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   a_i, b_i  : raw asynchronous beam sensors (street side a, lot side b)
//   entry_o   : 1-cycle pulse when a car completes an entry
//   exit_o    : 1-cycle pulse when a car completes an exit
//   fault_o   : 1-cycle pulse on an illegal debounced sensor transition
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  output logic entry_o,
  output logic exit_o,
  output logic fault_o
);

  localparam int DC_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      cand_q;
  logic [DC_W-1:0] cnt_q;
  logic [1:0]      deb_q;
  lane_state_e     state_q;
  logic            entry_q, exit_q, fault_q;

  // Synchroniser stage: pair is {a, b}
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {a_i, b_i};
      sync2_q <= sync1_q;
    end
  end

  // Debounce stage: a new synced pair becomes the candidate; it is accepted
  // only after it has stayed unchanged for DEB_CYCLES further samples, so a
  // change shorter than that never reaches the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= 2'b00;
      cnt_q  <= '0;
      deb_q  <= 2'b00;
    end else if (sync2_q != cand_q) begin
      cand_q <= sync2_q;
      cnt_q  <= '0;
    end else if (cnt_q >= DC_W'(DEB_CYCLES - 1)) begin
      deb_q <= cand_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Direction FSM stage: events registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          case (deb_q)
            2'b00: state_q <= ST_IDLE;
            2'b10: state_q <= ST_IN_A;
            2'b01: state_q <= ST_OUT_B;
            default: begin state_q <= ST_WAIT_CLR; fault_q <= 1'b1; end
          endcase
        end
        ST_IN_A: begin
          case (deb_q)
            2'b10: state_q <= ST_IN_A;
            2'b11: state_q <= ST_IN_AB;
            2'b00: state_q <= ST_IDLE;
            default: begin state_q <= ST_WAIT_CLR; fault_q <= 1'b1; end
          endcase
        end
        ST_IN_AB: begin
          case (deb_q)
            2'b11: state_q <= ST_IN_AB;
            2'b01: state_q <= ST_IN_B;
            2'b10: state_q <= ST_IN_A;
            default: begin state_q <= ST_WAIT_CLR; fault_q <= 1'b1; end
          endcase
        end
        ST_IN_B: begin
          case (deb_q)
            2'b01: state_q <= ST_IN_B;
            2'b00: begin state_q <= ST_IDLE; entry_q <= 1'b1; end
            2'b11: state_q <= ST_IN_AB;
            default: begin state_q <= ST_WAIT_CLR; fault_q <= 1'b1; end
          endcase
        end
        ST_OUT_B: begin
          case (deb_q)
            2'b01: state_q <= ST_OUT_B;
            2'b11: state_q <= ST_OUT_AB;
            2'b00: state_q <= ST_IDLE;
            default: begin state_q <= ST_WAIT_CLR; fault_q <= 1'b1; end
          endcase
        end
        ST_OUT_AB: begin
          case (deb_q)
            2'b11: state_q <= ST_OUT_AB;
            2'b10: state_q <= ST_OUT_A;
            2'b01: state_q <= ST_OUT_B;
            default: begin state_q <= ST_WAIT_CLR; fault_q <= 1'b1; end
          endcase
        end
        ST_OUT_A: begin
          case (deb_q)
            2'b10: state_q <= ST_OUT_A;
            2'b00: begin state_q <= ST_IDLE; exit_q <= 1'b1; end
            2'b11: state_q <= ST_OUT_AB;
            default: begin state_q <= ST_WAIT_CLR; fault_q <= 1'b1; end
          endcase
        end
        default: begin
          // WAIT_CLR: ignore everything until the lane is fully clear
          if (deb_q == 2'b00) state_q <= ST_IDLE;
          else                state_q <= ST_WAIT_CLR;
        end
      endcase
    end
  end

  assign entry_o = entry_q;
  assign exit_o  = exit_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane parking lot occupancy controller.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   sens_a, sens_b    : raw per-lane beam sensors (1 = blocked)
//   clr_count         : synchronous clear of occupancy (lane FSMs untouched)
//   occupancy         : cars currently in the lot, saturating at CAPACITY
//   full, empty       : occupancy == CAPACITY / occupancy == 0
//   entry_evt/exit_evt: per-lane 1-cycle completed passage pulses
//   fault             : per-lane 1-cycle illegal-sequence pulse
//   overflow          : 1-cycle pulse, entries rejected because lot full
//   underflow         : 1-cycle pulse, exits ignored because lot empty
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter  int N_LANES    = 2,
  parameter  int CAPACITY   = 100,
  parameter  int DEB_CYCLES = DEB_CYCLES_DEF,
  localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] sens_a,
  input  logic [N_LANES-1:0] sens_b,
  input  logic               clr_count,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic [N_LANES-1:0] entry_evt,
  output logic [N_LANES-1:0] exit_evt,
  output logic [N_LANES-1:0] fault,
  output logic               overflow,
  output logic               underflow
);

  // Popcount width must hold N_LANES itself; sum width adds a sign bit.
  localparam int EW    = $clog2(N_LANES + 1);
  localparam int SUM_W = CNT_W + EW + 1;
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  logic [N_LANES-1:0] entry_w, exit_w, fault_w;

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      parking_lane_fsm #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .a_i     (sens_a[gi]),
        .b_i     (sens_b[gi]),
        .entry_o (entry_w[gi]),
        .exit_o  (exit_w[gi]),
        .fault_o (fault_w[gi])
      );
    end
  endgenerate

  logic [EW-1:0]           e_cnt, x_cnt;
  logic signed [SUM_W-1:0] sum_s;
  logic [CNT_W-1:0]        occ_d;
  logic [CNT_W-1:0]        occ_q;
  logic                    full_q, empty_q, ovf_q, unf_q;

  // Net entries/exits first, then saturate into [0, CAPACITY]
  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int i = 0; i < N_LANES; i++) begin
      e_cnt = e_cnt + EW'(entry_w[i]);
      x_cnt = x_cnt + EW'(exit_w[i]);
    end
    sum_s = SUM_W'(occ_q) + SUM_W'(e_cnt) - SUM_W'(x_cnt);
    occ_d = CNT_W'(clamp_occ(int'(sum_s), CAPACITY));
  end

  // Counter stage: clr_count overrides any same-cycle events
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      full_q  <= (occ_d == CNT_W'(CAPACITY));
      empty_q <= (occ_d == '0);
      ovf_q   <= (sum_s > CAP_S);
      unf_q   <= (sum_s < 0);
    end
  end

  assign occupancy = occ_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign entry_evt = entry_w;
  assign exit_evt  = exit_w;
  assign fault     = fault_w;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
module tb_parking_occupancy_ctrl;

  localparam int N_LANES = 2;
  localparam int CAP     = 3;
  localparam int DEB     = 4;
  localparam int CNT_W   = $clog2(CAP + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic [N_LANES-1:0] sens_a, sens_b;
  logic               clr_count;
  logic [CNT_W-1:0]   occupancy;
  logic               full, empty, overflow, underflow;
  logic [N_LANES-1:0] entry_evt, exit_evt, fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse-cycle counters, only ever incremented here
  int ent0 = 0, ent1 = 0, ext0 = 0, ext1 = 0, flt0 = 0, flt1 = 0;
  int ovf_n = 0, unf_n = 0, both_n = 0;

  parking_occupancy_ctrl #(
    .N_LANES    (N_LANES),
    .CAPACITY   (CAP),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sens_a    (sens_a),
    .sens_b    (sens_b),
    .clr_count (clr_count),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .entry_evt (entry_evt),
    .exit_evt  (exit_evt),
    .fault     (fault),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (entry_evt[0]) ent0++;
    if (entry_evt[1]) ent1++;
    if (exit_evt[0])  ext0++;
    if (exit_evt[1])  ext1++;
    if (fault[0])     flt0++;
    if (fault[1])     flt1++;
    if (overflow)     ovf_n++;
    if (underflow)    unf_n++;
    if (entry_evt[0] && exit_evt[1]) both_n++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [1:0] ab);
    sens_a[lane] = ab[1];
    sens_b[lane] = ab[0];
  endtask

  // steps = {s0,s1,s2,s3}, each {a,b}, each held 10 cycles, then settle
  task automatic run_seq(input int lane, input logic [7:0] steps);
    logic [1:0] s;
    for (int k = 3; k >= 0; k--) begin
      s = steps[k*2 +: 2];
      set_lane(lane, s);
      cycles(10);
    end
    cycles(6);
  endtask

  task automatic run_dual(input logic [7:0] st0, input logic [7:0] st1);
    logic [1:0] s0, s1;
    for (int k = 3; k >= 0; k--) begin
      s0 = st0[k*2 +: 2];
      s1 = st1[k*2 +: 2];
      set_lane(0, s0);
      set_lane(1, s1);
      cycles(10);
    end
    cycles(6);
  endtask

  localparam logic [7:0] ENTRY   = 8'b10_11_01_00;
  localparam logic [7:0] EXIT    = 8'b01_11_10_00;
  localparam logic [7:0] BACKOUT = 8'b10_11_10_00;

  task automatic test_reset();
    rst = 1'b1; clr_count = 1'b0; sens_a = '0; sens_b = '0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++; if ({entry_evt, exit_evt, fault, overflow, underflow} !== '0) begin
      n_fail++; $display("FAIL reset_pulses got %b exp 0", {entry_evt, exit_evt, fault, overflow, underflow}); end
    cycles(1);
  endtask

  task automatic test_entry();
    int e0 = ent0, e1 = ent1, f = flt0 + flt1;
    run_seq(0, ENTRY);
    n_checks++; if (ent0 - e0 !== 1) begin n_fail++; $display("FAIL entry_evt0 got %0d exp 1", ent0 - e0); end
    n_checks++; if (ent1 - e1 !== 0) begin n_fail++; $display("FAIL entry_evt1 got %0d exp 0", ent1 - e1); end
    n_checks++; if (flt0 + flt1 - f !== 0) begin n_fail++; $display("FAIL entry_fault got %0d exp 0", flt0 + flt1 - f); end
    n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL entry_occ got %0d exp 1", occupancy); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL entry_empty got %b exp 0", empty); end
  endtask

  task automatic test_exit();
    int x1 = ext1, u = unf_n;
    run_seq(1, EXIT);
    n_checks++; if (ext1 - x1 !== 1) begin n_fail++; $display("FAIL exit_evt1 got %0d exp 1", ext1 - x1); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL exit_occ got %0d exp 0", occupancy); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL exit_empty got %b exp 1", empty); end
    n_checks++; if (unf_n - u !== 0) begin n_fail++; $display("FAIL exit_unf got %0d exp 0", unf_n - u); end
    run_seq(1, EXIT);
    n_checks++; if (ext1 - x1 !== 2) begin n_fail++; $display("FAIL exit2_evt1 got %0d exp 2", ext1 - x1); end
    n_checks++; if (unf_n - u !== 1) begin n_fail++; $display("FAIL underflow got %0d exp 1", unf_n - u); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL underflow_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_backout_fault();
    int ev = ent0 + ext0, f = flt0;
    run_seq(0, BACKOUT);
    n_checks++; if (ent0 + ext0 - ev !== 0) begin n_fail++; $display("FAIL backout_evt got %0d exp 0", ent0 + ext0 - ev); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL backout_occ got %0d exp 0", occupancy); end
    // 00 -> 11 in one debounced step, then wander without returning to 00
    set_lane(0, 2'b11); cycles(12);
    n_checks++; if (flt0 - f !== 1) begin n_fail++; $display("FAIL fault0 got %0d exp 1", flt0 - f); end
    set_lane(0, 2'b01); cycles(12);
    set_lane(0, 2'b10); cycles(12);
    set_lane(0, 2'b00); cycles(12);
    n_checks++; if (ent0 + ext0 - ev !== 0) begin n_fail++; $display("FAIL waitclr_evt got %0d exp 0", ent0 + ext0 - ev); end
    n_checks++; if (flt0 - f !== 1) begin n_fail++; $display("FAIL waitclr_fault got %0d exp 1", flt0 - f); end
    run_seq(0, ENTRY);
    n_checks++; if (ent0 - ev !== 1) begin n_fail++; $display("FAIL recover_entry got %0d exp 1", ent0 - ev); end
    n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL recover_occ got %0d exp 1", occupancy); end
  endtask

  task automatic test_capacity();
    int o = ovf_n, b = both_n;
    run_seq(0, ENTRY);
    run_seq(1, ENTRY);
    n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL cap_occ got %0d exp 3", occupancy); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL cap_full got %b exp 1", full); end
    n_checks++; if (ovf_n - o !== 0) begin n_fail++; $display("FAIL cap_ovf_early got %0d exp 0", ovf_n - o); end
    run_seq(0, ENTRY);
    n_checks++; if (ovf_n - o !== 1) begin n_fail++; $display("FAIL overflow got %0d exp 1", ovf_n - o); end
    n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL overflow_occ got %0d exp 3", occupancy); end
    run_dual(ENTRY, EXIT);
    n_checks++; if (both_n - b !== 1) begin n_fail++; $display("FAIL simul_same_cycle got %0d exp 1", both_n - b); end
    n_checks++; if (ovf_n - o !== 1) begin n_fail++; $display("FAIL simul_ovf got %0d exp 1", ovf_n - o); end
    n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL simul_occ got %0d exp 3", occupancy); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_full got %b exp 1", full); end
  endtask

  task automatic test_reset_mid();
    int e = ent0 + ext0, f = flt0;
    set_lane(0, 2'b10); cycles(10);
    set_lane(0, 2'b11); cycles(10);
    rst = 1'b1;
    set_lane(0, 2'b01);
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (occupancy !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags got occ=%0d e=%b f=%b exp 0/1/0", occupancy, empty, full); end
    n_checks++; if ({entry_evt, exit_evt, fault, overflow, underflow} !== '0) begin
      n_fail++; $display("FAIL rstmid_pulses got %b exp 0", {entry_evt, exit_evt, fault, overflow, underflow}); end
    cycles(10);
    set_lane(0, 2'b00); cycles(16);
    n_checks++; if (ent0 + ext0 - e !== 0) begin n_fail++; $display("FAIL rstmid_evt got %0d exp 0", ent0 + ext0 - e); end
    n_checks++; if (flt0 - f !== 0) begin n_fail++; $display("FAIL rstmid_fault got %0d exp 0", flt0 - f); end
  endtask

  task automatic test_glitch();
    int ev = ent0 + ext0 + flt0;
    sens_a[0] = 1'b1; cycles(1);
    sens_a[0] = 1'b0; cycles(15);
    n_checks++; if (ent0 + ext0 + flt0 - ev !== 0) begin n_fail++; $display("FAIL glitch_evt got %0d exp 0", ent0 + ext0 + flt0 - ev); end
    run_seq(0, ENTRY);
    n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL glitch_then_entry got %0d exp 1", occupancy); end
  endtask

  task automatic test_clear();
    clr_count = 1'b1; cycles(1);
    clr_count = 1'b0;
    n_checks++; if (occupancy !== '0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL clear got occ=%0d empty=%b exp 0/1", occupancy, empty); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_backout_fault();
    test_capacity();
    test_reset_mid();
    test_glitch();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
